// File: rtl/sim_uart_rx_monitor.sv
// sim_uart_rx_monitor
//
// Simulation-side UART receiver. It watches the chip's UART TX pad output,
// decodes 8N1 frames at a fixed clocks-per-bit ratio, and queues the received
// bytes in a small FIFO. The FIFO is read through a valid/ready interface.
// Framing errors and bytes dropped on a full FIFO are each counted.
//
// Parameters:
//   ClksPerBit  clk_i cycles per UART bit (>= 4)
//   FifoDepth   byte FIFO entries (power of two, >= 2)
//   CntW        width of the overflow and frame-error counters
//
// Ports:
//   clk_i            sim clock, same clock as the chip top
//   rst_ni           asynchronous active-low reset
//   rx_i             serial line, idle high
//   rdata_o          head-of-FIFO byte (0 when the FIFO is empty)
//   rvalid_o         FIFO non-empty
//   rready_i         consumer accepts rdata_o when rvalid_o is high
//   busy_o           receiver FSM not idle
//   frame_err_o      one-cycle pulse on a bad stop bit
//   frame_err_cnt_o  saturating count of framing errors
//   ovf_cnt_o        saturating count of bytes dropped on a full FIFO
//   depth_o          current FIFO occupancy

module sim_uart_rx_monitor #(
    parameter int unsigned ClksPerBit = 69,
    parameter int unsigned FifoDepth  = 8,
    parameter int unsigned CntW       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rx_i,
    output logic [7:0]                   rdata_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic                         busy_o,
    output logic                         frame_err_o,
    output logic [CntW-1:0]              frame_err_cnt_o,
    output logic [CntW-1:0]              ovf_cnt_o,
    output logic [$clog2(FifoDepth):0]   depth_o
);

    localparam int unsigned AW      = $clog2(FifoDepth);
    localparam int unsigned BitCntW = $clog2(ClksPerBit);
    localparam logic [BitCntW-1:0] LastCnt = BitCntW'(ClksPerBit - 1);
    localparam logic [BitCntW-1:0] HalfCnt = BitCntW'(ClksPerBit / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Input synchronizer and edge detect
    logic       sync1_q, sync2_q, sync3_q;
    logic [1:0] arm_q;
    logic       line;
    logic       fall;

    // Receiver FSM
    state_e               state_q, state_d;
    logic [BitCntW-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 push;
    logic                 ferr;

    // Status
    logic                 frame_err_q;
    logic [CntW-1:0]      ferr_cnt_q;
    logic [CntW-1:0]      ovf_cnt_q;

    // FIFO
    logic [7:0]           mem_q [FifoDepth];
    logic [AW:0]          wptr_q, rptr_q;
    logic                 full, empty, pop, push_ok, ovf;

    // Two-flop synchronizer plus a third flop for edge detection. All three
    // reset to the idle level. arm_q counts the first three clocks after
    // reset so that sync3_q holds a real line sample before any edge is
    // believed; a line that is already low at reset release therefore never
    // looks like a start bit and has to return high first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            arm_q   <= 2'd0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    assign line = sync2_q;
    assign fall = (arm_q == 2'd3) && sync3_q && !sync2_q;

    // FSM state register along with the bit-timing counter, bit index and
    // data shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic. The start bit is re-checked at its midpoint to reject
    // glitches; after that every sample lands a full bit period later, so
    // data and stop bits are all sampled near their centres.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d = '0;
                    if (!line) begin
                        idx_d   = 3'd0;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = line;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (line) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr    = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // A low stop bit may be a break condition; stay here until
                // the line is released so no bogus frame starts inside it.
                if (line) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o = (state_q != StIdle);

    // Frame-error pulse and saturating status counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_q <= 1'b0;
            ferr_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            frame_err_q <= ferr;
            if (ferr && (ferr_cnt_q != '1)) begin
                ferr_cnt_q <= ferr_cnt_q + 1'b1;
            end
            if (ovf && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    assign frame_err_o     = frame_err_q;
    assign frame_err_cnt_o = ferr_cnt_q;
    assign ovf_cnt_o       = ovf_cnt_q;

    // FIFO flags. Pointers carry one extra wrap bit so full and empty are
    // distinguishable. A push into a full FIFO still succeeds when a pop
    // happens in the same cycle, since the freed slot is the one written.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = !empty && rready_i;
    assign push_ok = push && (!full || pop);
    assign ovf     = push && full && !pop;

    // FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because reads are masked while
    // the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rvalid_o = !empty;
    assign rdata_o  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign depth_o  = wptr_q - rptr_q;

endmodule

// File: tb/tb_sim_uart_rx_monitor.sv
// tb_sim_uart_rx_monitor
//
// Self-checking bench for sim_uart_rx_monitor. Serial frames are generated
// at the bit level; a queue of expected bytes plus expected counter values
// form the reference model. A negedge monitor checks every byte handed over
// on the valid/ready interface against the head of the expected queue.

module tb_sim_uart_rx_monitor;

    localparam int ClksPerBit = 69;
    localparam int FifoDepth  = 8;
    localparam int CntW       = 16;
    localparam int DepthW     = $clog2(FifoDepth) + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              rx_i;
    logic              rready_i;
    logic [7:0]        rdata_o;
    logic              rvalid_o;
    logic              busy_o;
    logic              frame_err_o;
    logic [CntW-1:0]   frame_err_cnt_o;
    logic [CntW-1:0]   ovf_cnt_o;
    logic [DepthW-1:0] depth_o;

    int vectors      = 0;
    int miscompares  = 0;
    int errSeen      = 0;
    int rvalidCycles = 0;
    int expErrCnt    = 0;
    int expOvfCnt    = 0;
    int expErrPulses = 0;
    logic [7:0] expQ[$];
    logic [7:0] headByte;
    logic       randDone;

    sim_uart_rx_monitor #(
        .ClksPerBit (ClksPerBit),
        .FifoDepth  (FifoDepth),
        .CntW       (CntW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rx_i            (rx_i),
        .rdata_o         (rdata_o),
        .rvalid_o        (rvalid_o),
        .rready_i        (rready_i),
        .busy_o          (busy_o),
        .frame_err_o     (frame_err_o),
        .frame_err_cnt_o (frame_err_cnt_o),
        .ovf_cnt_o       (ovf_cnt_o),
        .depth_o         (depth_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard time limit so the bench can never hang.
    initial begin
        #(10 * 90000);
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: every handshake must deliver the oldest byte the
    // model expects.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (frame_err_o) errSeen++;
            if (rvalid_o) rvalidCycles++;
            if (rvalid_o && rready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousByte", 32'(rdata_o) | 32'h100, 32'h0);
                end else begin
                    headByte = expQ.pop_front();
                    checkOutput("rdata", 32'(rdata_o), 32'(headByte));
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic driveBit(input logic b, input int n);
        rx_i = b;
        waitCycles(n);
    endtask

    // One 8N1 frame, LSB first. A bad stop bit holds the line low for an
    // extra holdLow cycles before releasing it.
    task automatic applyStimulus(input logic [7:0] data, input logic goodStop, input int holdLow);
        driveBit(1'b0, ClksPerBit);
        for (int i = 0; i < 8; i++) driveBit(data[i], ClksPerBit);
        if (goodStop) begin
            driveBit(1'b1, ClksPerBit);
        end else begin
            driveBit(1'b0, ClksPerBit + holdLow);
            rx_i = 1'b1;
        end
    endtask

    // Reference model: a good frame is stored if there is room (or a pop
    // frees a slot in the same cycle), otherwise it is counted as dropped.
    task automatic modelSend(input logic [7:0] data, input logic goodStop, input logic popSameCycle);
        if (goodStop) begin
            if ((expQ.size() < FifoDepth) || popSameCycle) expQ.push_back(data);
            else if (expOvfCnt < (2**CntW - 1)) expOvfCnt++;
        end else begin
            expErrPulses++;
            if (expErrCnt < (2**CntW - 1)) expErrCnt++;
        end
    endtask

    task automatic drainAndCheck(input string tag);
        rready_i = 1'b1;
        for (int i = 0; i < 40 && expQ.size() != 0; i++) waitCycles(1);
        waitCycles(2);
        checkOutput({tag, "Drained"}, 32'(expQ.size()), 32'(0));
        checkOutput({tag, "Depth"}, 32'(depth_o), 32'(0));
        checkOutput({tag, "Rvalid"}, 32'(rvalid_o), 32'(0));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Rvalid"}, 32'(rvalid_o), 32'(0));
        checkOutput({tag, "Rdata"}, 32'(rdata_o), 32'(0));
        checkOutput({tag, "Busy"}, 32'(busy_o), 32'(0));
        checkOutput({tag, "FerrPulse"}, 32'(frame_err_o), 32'(0));
        checkOutput({tag, "FerrCnt"}, 32'(frame_err_cnt_o), 32'(0));
        checkOutput({tag, "OvfCnt"}, 32'(ovf_cnt_o), 32'(0));
        checkOutput({tag, "Depth"}, 32'(depth_o), 32'(0));
    endtask

    initial begin
        int startCnt;
        logic [7:0] data;
        logic good;
        int hold;
        logic [7:0] partial;

        rx_i     = 1'b1;
        rready_i = 1'b0;
        rst_ni   = 1'b0;
        randDone = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkResetValues("reset");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        waitCycles(5);

        // Two back-to-back bytes, consumer always ready.
        rready_i = 1'b1;
        startCnt = rvalidCycles;
        modelSend(8'h55, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 0);
        modelSend(8'hA3, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b1, 0);
        waitCycles(5);
        checkOutput("basicRvalidCycles", 32'(rvalidCycles - startCnt), 32'(2));
        checkOutput("basicFerrCnt", 32'(frame_err_cnt_o), 32'(expErrCnt));
        drainAndCheck("basic");

        // Short low glitch must not be accepted as a start bit.
        startCnt = rvalidCycles;
        driveBit(1'b0, 10);
        checkOutput("glitchBusyHigh", 32'(busy_o), 32'(1));
        driveBit(1'b0, 10);
        rx_i = 1'b1;
        waitCycles(25);
        checkOutput("glitchBusyLow", 32'(busy_o), 32'(0));
        waitCycles(700);
        checkOutput("glitchNoByte", 32'(rvalidCycles - startCnt), 32'(0));

        // Bad stop bit followed by a long break, then a clean byte.
        startCnt = errSeen;
        modelSend(8'h7E, 1'b0, 1'b0);
        applyStimulus(8'h7E, 1'b0, 300);
        waitCycles(10);
        checkOutput("ferrPulses", 32'(errSeen - startCnt), 32'(1));
        checkOutput("ferrCnt", 32'(frame_err_cnt_o), 32'(expErrCnt));
        checkOutput("ferrNoPush", 32'(depth_o), 32'(expQ.size()));
        modelSend(8'h41, 1'b1, 1'b0);
        applyStimulus(8'h41, 1'b1, 0);
        drainAndCheck("afterBreak");

        // Randomized frames with a randomly stalling consumer.
        startCnt = errSeen - expErrPulses;
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    data = 8'($urandom_range(0, 255));
                    good = ($urandom_range(0, 5) != 0);
                    hold = $urandom_range(0, 100);
                    modelSend(data, good, 1'b0);
                    applyStimulus(data, good, hold);
                    waitCycles(good ? $urandom_range(0, 20) : $urandom_range(5, 20));
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk_i);
                    #1 rready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        drainAndCheck("random");
        checkOutput("randomFerrPulses", 32'(errSeen - startCnt), 32'(expErrPulses));
        checkOutput("randomFerrCnt", 32'(frame_err_cnt_o), 32'(expErrCnt));
        checkOutput("randomOvfCnt", 32'(ovf_cnt_o), 32'(expOvfCnt));

        // Overflow: ten bytes with the consumer stalled.
        rready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            modelSend(8'(i), 1'b1, 1'b0);
            applyStimulus(8'(i), 1'b1, 0);
        end
        waitCycles(5);
        checkOutput("fullDepth", 32'(depth_o), 32'(FifoDepth));
        checkOutput("fullModelDepth", 32'(depth_o), 32'(expQ.size()));
        checkOutput("fullOvfCnt", 32'(ovf_cnt_o), 32'(expOvfCnt));
        checkOutput("fullRvalid", 32'(rvalid_o), 32'(1));

        // Full FIFO, one pop landing on the very cycle the byte is pushed.
        modelSend(8'h10, 1'b1, 1'b1);
        fork
            applyStimulus(8'h10, 1'b1, 0);
            begin
                repeat (657) @(posedge clk_i);
                #1 rready_i = 1'b1;
                @(posedge clk_i);
                #1 rready_i = 1'b0;
            end
        join
        waitCycles(5);
        checkOutput("popPushDepth", 32'(depth_o), 32'(FifoDepth));
        checkOutput("popPushOvfCnt", 32'(ovf_cnt_o), 32'(expOvfCnt));
        drainAndCheck("popPush");

        // Reset in the middle of data bit 4 with a byte already queued.
        rready_i = 1'b0;
        modelSend(8'h5A, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b1, 0);
        checkOutput("preResetDepth", 32'(depth_o), 32'(1));
        partial = 8'hC3;
        driveBit(1'b0, ClksPerBit);
        for (int i = 0; i < 4; i++) driveBit(partial[i], ClksPerBit);
        driveBit(partial[4], 30);
        checkOutput("midFrameBusy", 32'(busy_o), 32'(1));
        rx_i   = 1'b1;
        rst_ni = 1'b0;
        expQ.delete();
        expErrCnt = 0;
        expOvfCnt = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkResetValues("midReset");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        waitCycles(10);
        rready_i = 1'b1;
        modelSend(8'hC3, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b1, 0);
        drainAndCheck("postReset");
        checkOutput("postResetFerrCnt", 32'(frame_err_cnt_o), 32'(expErrCnt));
        checkOutput("postResetOvfCnt", 32'(ovf_cnt_o), 32'(expOvfCnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
